// File: rtl/galois_pow_d.sv
// galois_pow_d: streaming x^D_EXP mod PRIME_MODULUS by MSB-first square-and-multiply
// over one shared pipelined Barrett multiplier; one element in flight at a time.
`default_nettype none

module galois_mult_barrett_sync #(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter logic [N_BITS:0]   BARRETT_R     = 255'h54a47462623a04a7ab074a58680730147144852009e880ae620703a6be1de925,
  parameter int                LATENCY       = 12
) (
  input  logic              clk,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS-1:0] product
);
  // The caller's operand registers count as the first of LATENCY stages, so the
  // product is presented from LATENCY-1 internal register stages (needs LATENCY >= 4).
  localparam int W2 = 2 * N_BITS;
  localparam int WR = N_BITS + 2;
  localparam logic [WR-1:0] P_EXT = WR'(PRIME_MODULUS);

  logic [W2-1:0]     prod_s1;
  logic [W2+1:0]     q2;
  logic [N_BITS:0]   q3;
  logic [N_BITS:0]   q3_s2;
  logic [WR-1:0]     x_lo_s2;
  logic [WR-1:0]     r0;
  logic [WR-1:0]     r1;
  logic [WR-1:0]     r2;
  logic [N_BITS-1:0] res_s3;

  always_comb begin
    q2 = (W2 + 2)'(prod_s1 >> (N_BITS - 1)) * (W2 + 2)'(BARRETT_R);
    q3 = (N_BITS + 1)'(q2 >> (N_BITS + 1));
  end

  // True remainder is below 3p < 2^(N_BITS+2), so the low bits alone suffice.
  always_comb begin
    r0 = x_lo_s2 - WR'(WR'(q3_s2) * P_EXT);
    r1 = (r0 >= P_EXT) ? r0 - P_EXT : r0;
    r2 = (r1 >= P_EXT) ? r1 - P_EXT : r1;
  end

  always_ff @(posedge clk) begin
    prod_s1 <= W2'(a) * W2'(b);
    q3_s2   <= q3;
    x_lo_s2 <= prod_s1[WR-1:0];
    res_s3  <= r2[N_BITS-1:0];
  end

  if (LATENCY > 4) begin : g_delay
    logic [N_BITS-1:0] pipe [LATENCY-4];
    always_ff @(posedge clk) begin
      pipe[0] <= res_s3;
      for (int i = 1; i < LATENCY - 4; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
    assign product = pipe[LATENCY-5];
  end else begin : g_direct
    assign product = res_s3;
  end
endmodule

module galois_pow_d #(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter logic [N_BITS:0]   BARRETT_R     = 255'h54a47462623a04a7ab074a58680730147144852009e880ae620703a6be1de925,
  parameter int                D_EXP         = 5,
  parameter int                MULT_LATENCY  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_data
);
  localparam int D_BITS = $clog2(D_EXP + 1);
  localparam int IDX_W  = (D_BITS > 1) ? $clog2(D_BITS) : 1;
  localparam int CNT_W  = $clog2(MULT_LATENCY + 1);
  localparam logic [D_BITS-1:0] D_VEC    = D_BITS'(D_EXP);
  localparam logic [IDX_W-1:0]  IDX_INIT = IDX_W'((D_BITS > 1) ? D_BITS - 2 : 0);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MULT_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_nx;
  logic [N_BITS-1:0] x_reg;
  logic [N_BITS-1:0] acc;
  logic [N_BITS-1:0] op_a;
  logic [N_BITS-1:0] op_b;
  logic [N_BITS-1:0] product;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic              phase_mul;
  logic              op_last;
  logic              need_mul;

  galois_mult_barrett_sync #(
    .N_BITS        (N_BITS),
    .PRIME_MODULUS (PRIME_MODULUS),
    .BARRETT_R     (BARRETT_R),
    .LATENCY       (MULT_LATENCY)
  ) u_mult (
    .clk     (clk),
    .a       (op_a),
    .b       (op_b),
    .product (product)
  );

  assign in_ready = (state == IDLE);
  assign op_last  = (cnt == CNT_LAST);
  assign need_mul = !phase_mul && D_VEC[idx];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = (D_EXP == 1) ? DONE : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT: begin
        if (op_last) begin
          if (need_mul || idx != '0) state_nx = ISSUE;
          else                       state_nx = DONE;
        end
      end
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg     <= '0;
      acc       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      idx       <= '0;
      cnt       <= '0;
      phase_mul <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg     <= in_data;
            acc       <= in_data;
            idx       <= IDX_INIT;
            phase_mul <= 1'b0;
          end
        end
        ISSUE: begin
          op_a <= acc;
          op_b <= phase_mul ? x_reg : acc;
          cnt  <= CNT_W'(1);
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (op_last) begin
            acc <= product;
            if (need_mul) begin
              phase_mul <= 1'b1;
            end else if (idx != '0) begin
              idx       <= idx - IDX_W'(1);
              phase_mul <= 1'b0;
            end
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; it then holds until accepted.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_galois_pow_d.sv
// tb_galois_pow_d: table vectors, inverse-power round trips and handshake corner cases
// for galois_pow_d, checked against a modular-arithmetic reference model.
`default_nettype none

module tb_galois_pow_d;
  localparam int N = 254;
  localparam logic [N-1:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam int D = 5;
  localparam int LAT_EXP = 40;

  typedef struct {
    logic [N-1:0] din;
    logic [N-1:0] dout;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  galois_pow_d dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] t;
    t = (2*N)'(a) * (2*N)'(b);
    return N'(t % (2*N)'(P));
  endfunction

  function automatic logic [N-1:0] powmod(input logic [N-1:0] base, input logic [N-1:0] e);
    logic [N-1:0] r;
    r = N'(1);
    for (int i = N - 1; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, base);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_elem();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[N-1:0] % P;
  endfunction

  // Exponent e with D*e == 1 mod (P-1): the inverse power map.
  function automatic logic [N-1:0] inv_exp();
    logic [N+3:0] t;
    logic [N-1:0] e;
    e = '0;
    for (int k = 1; k <= 4; k++) begin
      t = (N+4)'(k) * ((N+4)'(P) - (N+4)'(1)) + (N+4)'(1);
      if (t % (N+4)'(D) == '0) e = N'(t / (N+4)'(D));
    end
    return e;
  endfunction

  task automatic run_one(input logic [N-1:0] x, input logic [N-1:0] exp, input string name,
                         input bit hold_valid, input int bp_cycles);
    int cyc;
    logic [N-1:0] held;
    in_valid = 1'b1;
    in_data  = x;
    check({name, " in_ready"}, N'(in_ready), N'(1));
    tick();
    if (!hold_valid) in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      if (hold_valid) in_data = rand_elem();
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check({name, " latency"}, N'(cyc), N'(LAT_EXP));
    check({name, " data"}, out_data, exp);
    held = out_data;
    for (int i = 0; i < bp_cycles; i++) begin
      tick();
      check({name, " bp data"}, out_data, held);
      check({name, " bp in_ready"}, N'({in_ready, out_valid}), N'(2'b01));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " post hs"}, N'({in_ready, out_valid}), N'(2'b10));
  endtask

  vec_t         tbl [10];
  logic [N-1:0] e_inv;
  logic [N-1:0] b;
  logic [N-1:0] q [$];

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset in_ready", N'(in_ready), N'(1));
    check("reset out_valid", N'(out_valid), N'(0));
    check("reset out_data", out_data, '0);
    reset = 1'b0;
    tick();

    tbl[0] = '{N'(2), N'(32)};
    tbl[1] = '{P - N'(1), P - N'(1)};
    tbl[2] = '{N'(0), N'(0)};
    tbl[3] = '{N'(1), N'(1)};
    for (int i = 4; i < 10; i++) begin
      b = rand_elem();
      tbl[i] = '{b, powmod(b, N'(D))};
    end
    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i].din, tbl[i].dout, $sformatf("vec%0d", i), i == 0, 0);
    end

    e_inv = inv_exp();
    run_one(powmod(N'(7), e_inv), N'(7), "roundtrip7", 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      b = rand_elem();
      run_one(powmod(b, e_inv), b, $sformatf("roundtrip%0d", i), 1'b0, 0);
    end

    run_one(N'(4), N'(1024), "backpressure", 1'b0, 15);

    // Abort mid-operation with reset; nothing from the aborted element may appear.
    in_valid = 1'b1;
    in_data  = N'(9);
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort idle", N'({in_ready, out_valid}), N'(2'b10));
    begin
      logic saw;
      saw = 1'b0;
      for (int i = 0; i < 50; i++) begin
        tick();
        saw = saw | out_valid;
      end
      check("abort no stale", N'(saw), N'(0));
    end
    run_one(N'(3), N'(243), "post_reset", 1'b0, 0);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = N'(5);
    begin
      int acc_n;
      bit pre;
      acc_n = 0;
      for (int i = 0; i < 150; i++) begin
        pre = in_valid && in_ready;
        if (out_valid && out_ready) q.push_back(out_data);
        tick();
        if (pre) begin
          acc_n++;
          if (acc_n == 1) in_data = N'(6);
          if (acc_n == 2) in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b count", N'(q.size()), N'(2));
    check("b2b first", (q.size() > 0) ? q[0] : '0, N'(3125));
    check("b2b second", (q.size() > 1) ? q[1] : '0, N'(7776));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/galois_pow_d.md
Name: galois_pow_d

Overview:
- Forward power S-box: computes base^D_EXP mod PRIME_MODULUS (default x^5) for the Griffin permutation.
- Counterpart to galois_pow_dinv, which computes the inverse power x^(1/5). Feeding one block's output into the other must return the original element.
- Streaming valid/ready interface with a single galois_mult_barrett_sync instance, shared by all square and multiply steps.
- One operation in flight at a time.

Parameters:
- N_BITS, 254: field element width.
- PRIME_MODULUS, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001: field prime, passed to the multiplier.
- BARRETT_R, 255'h54a47462623a04a7ab074a58680730147144852009e880ae620703a6be1de925: Barrett constant (N_BITS+1 bits), passed to the multiplier.
- D_EXP, 5: exponent. Must be >= 1.
- MULT_LATENCY, 12: galois_mult_barrett_sync latency, in cycles from operand registers updating to a valid product.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  N_BITS  base. Must be < PRIME_MODULUS.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  N_BITS  base^D_EXP mod PRIME_MODULUS.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0; internal counters and bit index cleared.
- Reset mid-operation: aborts the operation and discards its data. IDLE follows on the next cycle; no spurious out_valid.
- Localparam D_BITS = $clog2(D_EXP+1).
- Algorithm: MSB-first square-and-multiply over D_EXP bits [D_BITS-2:0]. The accumulator starts at x, since the MSB is implicitly 1.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch x_reg<=in_data and acc<=in_data, set idx<=D_BITS-2, phase<=SQ.
  - Next state is ISSUE, or DONE directly if D_EXP==1.
- ISSUE (in_ready=0):
  - Register multiplier operands: (acc, acc) for phase SQ, (acc, x_reg) for phase MUL.
  - Clear the wait counter; go to WAIT.
- WAIT:
  - Counter increments from 1.
  - In the cycle the counter equals MULT_LATENCY: acc<=product, then choose the next step.
  - If phase SQ and D_EXP[idx]==1: phase<=MUL, go to ISSUE.
  - Otherwise, if idx==0: go to DONE.
  - Otherwise: idx<=idx-1, phase<=SQ, go to ISSUE.
- Op timing: each multiplier op takes exactly 1+MULT_LATENCY cycles.
- Op count: NOPS = (D_BITS-1) + popcount(D_EXP) - 1. For D=5, NOPS=3 (square, square, multiply).
- Latency: out_valid rises NOPS*(1+MULT_LATENCY)+1 cycles after the accepting edge. Defaults give 40 cycles.
- DONE:
  - out_valid=1 and out_data=acc.
  - Both are held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid<=0. in_ready rises the cycle after the output handshake.
  - An input is never accepted in the same cycle as the output handshake.
- in_data changes while busy are ignored; only the value latched at acceptance is used.
- Multiplier operands hold their last value outside ISSUE.
- Inputs >= PRIME_MODULUS are out of spec and are not checked.

Test Plan:
- Reset, then in_data=2 with in_valid held high: accepted on the first cycle; out_valid exactly 40 cycles later with out_data=32.
- in_data=PRIME_MODULUS-1: out_data=PRIME_MODULUS-1, since (-1)^5 = -1. in_data=0 gives 0; in_data=1 gives 1.
- Round trip: galois_pow_dinv(base=7) gives y; driving y into this block must give out_data=7. Repeat for 10 random elements < PRIME_MODULUS.
- Backpressure: hold out_ready=0 for 15 cycles after out_valid. out_data stays stable and in_ready stays 0; a release gives one handshake, then in_ready=1 on the next cycle.
- Reset asserted at cycle 20 of a computation, then in_data=3: no stale output; 243 is returned 40 cycles after the new accept.
- Back-to-back inputs 5 and 6 with out_ready tied high: outputs 3125 then 7776, in order, with no drops or duplicates.
